// File: rtl/rx_crc_ctrl_pkg.sv
// rx_crc_ctrl_pkg
//   Shared constants, state encoding and the bytewise CRC-32 step used by
//   the receive CRC datapath.
//   - CRC_INIT     : CRC register seed at start of frame
//   - CRC_RESIDUE  : register value after a correct FCS has been absorbed
//   - state_t      : controller states (IDLE / ACCUM / DONE)
//   - EOF_BYTES_ALL: eof_bytes code meaning "all 8 bytes valid"
//   - crc32_byte() : one-byte CRC-32 step, register kept in normal (MSB-first)
//                    form, data bits absorbed LSB first as they go on the wire
package rx_crc_ctrl_pkg;

  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
  localparam logic [2:0]  EOF_BYTES_ALL = 3'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Ethernet sends each byte LSB first, so bit 0 is absorbed first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/CRC32_D64.sv
// CRC32_D64
//   Full-word CRC-32 update: absorbs all 8 bytes of a 64-bit word.
//   - data     : 64-bit word, byte 0 (first on wire) in [63:56]
//   - crc      : base CRC register value
//   - next_crc : CRC after the 8 bytes
module CRC32_D64
  import rx_crc_ctrl_pkg::*;
(
  input  logic [63:0] data,
  input  logic [31:0] crc,
  output logic [31:0] next_crc
);

  always_comb begin
    next_crc = crc;
    for (int i = 0; i < 8; i++) begin
      next_crc = crc32_byte(next_crc, data[63-8*i -: 8]);
    end
  end

endmodule

// File: rtl/crc_bytes.sv
// crc_bytes
//   Partial-word CRC-32 taps for the final word of a frame.
//   - data     : the first 7 bytes of the word, byte 0 in [55:48]
//   - crc      : base CRC register value
//   - crc_byte : crc_byte[n] is the CRC after absorbing bytes 0..n-1 (n=1..7)
module crc_bytes
  import rx_crc_ctrl_pkg::*;
(
  input  logic [55:0]       data,
  input  logic [31:0]       crc,
  output logic [7:1][31:0]  crc_byte
);

  logic [31:0] c;

  // Each tap extends the previous one by one byte.
  always_comb begin
    c        = crc;
    crc_byte = '0;
    for (int n = 1; n <= 7; n++) begin
      c           = crc32_byte(c, data[55-8*(n-1) -: 8]);
      crc_byte[n] = c;
    end
  end

endmodule

// File: rtl/rx_crc_ctrl.sv
// rx_crc_ctrl
//   Frame-level sequencer for the 10G receive CRC-32 check. Seeds the running
//   CRC at sof, advances it 8 bytes per full word, picks the matching partial
//   tap on the eof word, compares against the CRC residue and reports the
//   result one cycle later together with saturating good/bad frame counters.
//   Ports:
//   - rxclk, reset           : clock, synchronous active-high reset
//   - data_in                : frame word, byte 0 in [63:56]
//   - data_valid, sof, eof   : word qualifiers
//   - eof_bytes              : valid bytes in the eof word (0 = 8)
//   - abort                  : discard the frame in progress
//   - crc_done/crc_ok/crc_bad: result pulse and verdict
//   - frame_dropped          : pulse when a frame is discarded
//   - busy                   : frame in progress
//   - good_cnt, bad_cnt      : saturating frame counters
//
// Word handshake: a word is taken on every rxclk edge where data_valid=1;
// sof and eof only have meaning on such words. There is no backpressure.
// abort is sampled every cycle regardless of data_valid and wins over eof.
module rx_crc_ctrl
  import rx_crc_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             rxclk,
  input  logic             reset,
  input  logic [63:0]      data_in,
  input  logic             data_valid,
  input  logic             sof,
  input  logic             eof,
  input  logic [2:0]       eof_bytes,
  input  logic             abort,
  output logic             crc_done,
  output logic             crc_ok,
  output logic             crc_bad,
  output logic             frame_dropped,
  output logic             busy,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  state_t           state, state_n;
  logic [31:0]      crc_reg, crc_n;
  logic             ok_q, ok_n;
  logic             drop_q, drop_n;
  logic [31:0]      base_crc;
  logic [31:0]      full_crc;
  logic [31:0]      final_crc;
  logic [7:1][31:0] taps;

  // A sof word always restarts from the seed, even mid-frame.
  assign base_crc = sof ? CRC_INIT : crc_reg;

  CRC32_D64 u_crc64 (
    .data     (data_in),
    .crc      (base_crc),
    .next_crc (full_crc)
  );

  crc_bytes u_crc_bytes (
    .data     (data_in[63:8]),
    .crc      (base_crc),
    .crc_byte (taps)
  );

  always_comb begin
    final_crc = full_crc;
    case (eof_bytes)
      3'd1:    final_crc = taps[1];
      3'd2:    final_crc = taps[2];
      3'd3:    final_crc = taps[3];
      3'd4:    final_crc = taps[4];
      3'd5:    final_crc = taps[5];
      3'd6:    final_crc = taps[6];
      3'd7:    final_crc = taps[7];
      default: final_crc = full_crc;
    endcase
  end

  always_ff @(posedge rxclk) begin
    if (reset) begin
      state   <= IDLE;
      crc_reg <= CRC_INIT;
      ok_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state   <= state_n;
      crc_reg <= crc_n;
      ok_q    <= ok_n;
      drop_q  <= drop_n;
    end
  end

  // DONE lasts one cycle; a sof in that cycle opens the next frame directly.
  always_comb begin
    state_n = (state == DONE) ? IDLE : state;
    crc_n   = crc_reg;
    ok_n    = ok_q;
    drop_n  = 1'b0;
    if (abort) begin
      if (state != IDLE) begin
        drop_n  = 1'b1;
        state_n = IDLE;
      end
    end else if (data_valid && (sof || state == ACCUM)) begin
      if (eof) begin
        ok_n    = (final_crc == CRC_RESIDUE);
        state_n = DONE;
      end else begin
        crc_n   = full_crc;
        state_n = ACCUM;
      end
      if (sof && state == ACCUM) begin
        drop_n = 1'b1;
      end
    end
  end

  always_ff @(posedge rxclk) begin
    if (reset) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (state == DONE) begin
      if (ok_q && good_cnt != '1) begin
        good_cnt <= good_cnt + 1'b1;
      end else if (!ok_q && bad_cnt != '1) begin
        bad_cnt <= bad_cnt + 1'b1;
      end
    end
  end

  assign crc_done      = (state == DONE);
  assign crc_ok        = (state == DONE) && ok_q;
  assign crc_bad       = (state == DONE) && !ok_q;
  assign frame_dropped = drop_q;
  assign busy          = (state == ACCUM);

endmodule

// File: tb/tb_rx_crc_ctrl.sv
// tb_rx_crc_ctrl
//   Directed bench for rx_crc_ctrl. Frames are built with a reference
//   reflected CRC-32 (poly 0xEDB88320) so the appended FCS is independent of
//   the DUT's bit ordering. A second instance with CNT_W=2 shares the inputs
//   and is used for the counter saturation case.
module tb_rx_crc_ctrl;

  // clock / reset
  logic        rxclk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        sof = 1'b0;
  logic        eof = 1'b0;
  logic [2:0]  eof_bytes = '0;
  logic        abort = 1'b0;

  logic        crc_done, crc_ok, crc_bad, frame_dropped, busy;
  logic [15:0] good_cnt, bad_cnt;
  logic        s_crc_done, s_crc_ok, s_crc_bad, s_frame_dropped, s_busy;
  logic [1:0]  s_good_cnt, s_bad_cnt;

  always #5 rxclk = ~rxclk;

  rx_crc_ctrl #(.CNT_W(16)) dut (
    .rxclk(rxclk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .sof(sof), .eof(eof), .eof_bytes(eof_bytes), .abort(abort),
    .crc_done(crc_done), .crc_ok(crc_ok), .crc_bad(crc_bad),
    .frame_dropped(frame_dropped), .busy(busy),
    .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  rx_crc_ctrl #(.CNT_W(2)) dut_sat (
    .rxclk(rxclk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .sof(sof), .eof(eof), .eof_bytes(eof_bytes), .abort(abort),
    .crc_done(s_crc_done), .crc_ok(s_crc_ok), .crc_bad(s_crc_bad),
    .frame_dropped(s_frame_dropped), .busy(s_busy),
    .good_cnt(s_good_cnt), .bad_cnt(s_bad_cnt)
  );

  int tests  = 0;
  int errors = 0;
  int n_done = 0;
  int n_drop = 0;

  // scoreboard: 2'b10 = expect crc_ok, 2'b01 = expect crc_bad
  logic [1:0] exp_q[$];

  logic [7:0] frame_b [0:127];
  int         frame_len = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // result monitor, sampled away from the active edge
  always @(negedge rxclk) begin
    if (frame_dropped) n_drop++;
    if (crc_done) begin
      n_done++;
      if (exp_q.size() == 0) check("unexpected_done", 32'(crc_done), 32'd0);
      else check("scoreboard_result", 32'({crc_ok, crc_bad}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rxclk);
      #1;
    end
  endtask

  task automatic drive(input logic [63:0] d, input logic v, input logic s,
                       input logic e, input logic [2:0] eb, input logic ab);
    data_in = d; data_valid = v; sof = s; eof = e; eof_bytes = eb; abort = ab;
    @(posedge rxclk);
    #1;
    data_in = '0; data_valid = 1'b0; sof = 1'b0; eof = 1'b0; eof_bytes = '0; abort = 1'b0;
  endtask

  // payload pattern plus FCS from a reflected reference CRC
  task automatic build_frame(input int payload_len, input int seed);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < payload_len; i++) begin
      frame_b[i] = 8'((i * 13 + seed) & 255);
      c = c ^ {24'h0, frame_b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    frame_b[payload_len]     = c[7:0];
    frame_b[payload_len + 1] = c[15:8];
    frame_b[payload_len + 2] = c[23:16];
    frame_b[payload_len + 3] = c[31:24];
    frame_len = payload_len + 4;
  endtask

  function automatic logic [63:0] word_at(input int w);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 8; k++)
      if (8 * w + k < frame_len) r[63-8*k -: 8] = frame_b[8*w + k];
    return r;
  endfunction

  // Sends words 0..last_word; eof only on the true final word.
  task automatic send_frame(input int last_word, input int gap_after,
                            input int gap_cycles, input int eb_force);
    int         nwords;
    logic [2:0] eb;
    logic       is_eof;
    nwords = (frame_len + 7) / 8;
    eb = (eb_force >= 0) ? 3'(eb_force) : 3'(frame_len % 8);
    for (int w = 0; w <= last_word; w++) begin
      is_eof = (w == nwords - 1);
      drive(word_at(w), 1'b1, w == 0, is_eof, is_eof ? eb : 3'd0, 1'b0);
      if (w == gap_after) tick(gap_cycles);
    end
  endtask

  initial begin
    int d0;
    tick(2);
    check("reset_flags", 32'({crc_done, crc_ok, crc_bad, frame_dropped, busy}), 32'd0);
    check("reset_good_cnt", 32'(good_cnt), 32'd0);
    check("reset_bad_cnt", 32'(bad_cnt), 32'd0);
    reset = 1'b0;
    tick(1);

    // good 64-byte frame, eof_bytes = 0
    build_frame(60, 3);
    exp_q.push_back(2'b10);
    send_frame(7, -1, 0, -1);
    check("good_done_latency", 32'(crc_done), 32'd1);
    check("good_ok", 32'({crc_ok, crc_bad}), 32'b10);
    tick(1);
    check("good_cnt_1", 32'(good_cnt), 32'd1);

    // eof outside a frame is ignored
    drive(64'h1122_3344_5566_7788, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0);
    check("stray_eof", 32'({crc_done, busy}), 32'd0);

    // corrupted: bit 0 of byte 20
    frame_b[20] = frame_b[20] ^ 8'h01;
    exp_q.push_back(2'b01);
    send_frame(7, -1, 0, -1);
    check("bad_verdict", 32'({crc_done, crc_ok, crc_bad}), 32'b101);
    tick(1);
    check("bad_cnt_1", 32'(bad_cnt), 32'd1);
    check("good_cnt_kept", 32'(good_cnt), 32'd1);

    // 67-byte frame, eof_bytes=3 good, forced eof_bytes=4 bad
    build_frame(63, 9);
    exp_q.push_back(2'b10);
    send_frame(8, -1, 0, -1);
    check("partial3_ok", 32'({crc_done, crc_ok}), 32'b11);
    tick(1);
    exp_q.push_back(2'b01);
    send_frame(8, -1, 0, 4);
    check("partial4_bad", 32'({crc_done, crc_bad}), 32'b11);
    tick(1);
    check("partial_cnts", 32'({good_cnt, bad_cnt}), {16'd2, 16'd2});

    // single-word frame: 3 payload bytes + FCS, eof_bytes = 7
    build_frame(3, 77);
    exp_q.push_back(2'b10);
    send_frame(0, -1, 0, -1);
    check("single_word_ok", 32'({crc_done, crc_ok}), 32'b11);
    tick(1);
    check("good_cnt_3", 32'(good_cnt), 32'd3);

    // abort on word 4
    build_frame(60, 21);
    d0 = n_drop;
    send_frame(2, -1, 0, -1);
    drive(word_at(3), 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    check("abort_drop", 32'({frame_dropped, crc_done, busy}), 32'b100);
    tick(3);
    check("abort_cnts", 32'({good_cnt, bad_cnt}), {16'd3, 16'd2});
    check("abort_drop_count", 32'(n_drop - d0), 32'd1);

    // sof on word 4 restarts with a full good frame
    d0 = n_drop;
    send_frame(2, -1, 0, -1);
    exp_q.push_back(2'b10);
    send_frame(7, -1, 0, -1);
    check("restart_ok", 32'({crc_done, crc_ok}), 32'b11);
    tick(1);
    check("restart_drop_count", 32'(n_drop - d0), 32'd1);
    check("good_cnt_4", 32'(good_cnt), 32'd4);

    // back-to-back, second frame with a 3-cycle gap
    d0 = n_done;
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b10);
    send_frame(7, -1, 0, -1);
    check("b2b_first_ok", 32'({crc_done, crc_ok}), 32'b11);
    send_frame(7, 2, 3, -1);
    check("b2b_second_ok", 32'({crc_done, crc_ok}), 32'b11);
    tick(1);
    check("b2b_done_count", 32'(n_done - d0), 32'd2);
    check("good_cnt_6", 32'(good_cnt), 32'd6);
    check("sat_cnt_pinned", 32'(s_good_cnt), 32'd3);

    // reset mid-frame
    d0 = n_drop;
    send_frame(2, -1, 0, -1);
    reset = 1'b1;
    tick(1);
    check("midreset_flags", 32'({crc_done, crc_ok, crc_bad, frame_dropped, busy}), 32'd0);
    check("midreset_cnts", 32'({good_cnt, bad_cnt}), 32'd0);
    reset = 1'b0;
    tick(3);
    check("midreset_no_drop", 32'(n_drop - d0), 32'd0);

    // saturation on the CNT_W=2 instance
    for (int f = 0; f < 5; f++) begin
      exp_q.push_back(2'b10);
      send_frame(7, -1, 0, -1);
    end
    tick(2);
    check("sat_good_cnt", 32'(s_good_cnt), 32'd3);
    check("sat_bad_cnt", 32'(s_bad_cnt), 32'd0);
    check("main_good_cnt_5", 32'(good_cnt), 32'd5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/rx_crc_ctrl.md
Name: rx_crc_ctrl

Overview:
Sequences the 10G receive CRC-32 datapath across a frame. It holds the running CRC register and seeds it at start of frame. Full 64-bit words advance it by 8 bytes; the final partial word takes the matching crc_byteN tap. The frame result is checked against the CRC residue, and the block reports good/bad status and keeps frame counters for the rx_engine.

Parameters:
CRC_INIT, 32'hFFFF_FFFF, CRC register seed loaded at start of frame
CRC_RESIDUE, 32'hC704_DD7B, expected CRC register value after the FCS has been absorbed
CNT_W, 16, width of the good/bad frame counters (saturating)

Ports:
rxclk  in  1  receive clock
reset  in  1  synchronous, active-high reset
data_in  in  64  frame word; byte 0 (first on wire) in [63:56]
data_valid  in  1  data_in carries frame bytes this cycle
sof  in  1  first word of a frame (qualified by data_valid)
eof  in  1  last word of a frame (qualified by data_valid)
eof_bytes  in  3  valid bytes in the eof word: 1..7, 0 = all 8
abort  in  1  receive error; discard the current frame
crc_done  out  1  one-cycle pulse: result valid
crc_ok  out  1  frame CRC matched residue (valid with crc_done)
crc_bad  out  1  frame CRC mismatched (valid with crc_done)
frame_dropped  out  1  one-cycle pulse: frame discarded (abort, or sof arriving mid-frame)
busy  out  1  frame in progress (state ACCUM)
good_cnt  out  CNT_W  saturating count of crc_ok frames
bad_cnt  out  CNT_W  saturating count of crc_bad frames

Behaviour:
- Clock and reset: one clock, rxclk; reset is synchronous and active-high.
- Reset values: state=IDLE, crc_reg=CRC_INIT, all pulse and flag outputs 0, counters 0. Reset mid-frame discards the frame silently, with no frame_dropped pulse.
- States:
  - IDLE: waits for sof&data_valid.
  - ACCUM: frame in progress.
  - DONE: single cycle that presents the result, then returns to IDLE.
- Word advance:
  - next_crc = 8-byte update of the selected base CRC with data_in.
  - Base CRC is CRC_INIT when sof is set, else crc_reg.
  - data_valid=0 means hold: crc_reg and state are unchanged.
- IDLE + sof & data_valid & !eof: crc_reg<=next_crc, go to ACCUM.
- IDLE + sof & eof in the same word: single-word frame; evaluate it as the eof case below.
- ACCUM + data_valid & !eof & !sof: crc_reg<=next_crc.
- eof word:
  - final = crc_byte[eof_bytes] tap, or the full 8-byte update when eof_bytes=0.
  - A registered compare (final==CRC_RESIDUE) is taken, and the state goes to DONE.
  - In DONE: crc_done=1, exactly one of crc_ok/crc_bad=1, and the matching counter increments unless it is at all-ones.
  - Latency: result appears exactly 1 cycle after the eof word is accepted.
- sof while in ACCUM:
  - frame_dropped pulses in the next cycle, with no crc_done.
  - The new frame restarts from CRC_INIT using the sof word.
- abort (any state except IDLE), or abort coinciding with eof:
  - frame_dropped pulses next cycle and the state returns to IDLE.
  - No crc_done and no counter change; abort takes priority over eof.
- data_valid outside a frame (IDLE, no sof): ignored.
- eof without an open frame and without sof: ignored.
- A new sof is accepted in the DONE cycle: DONE evaluates the previous result while a new frame begins (back-to-back frames with zero gap).
- Counters saturate at 2^CNT_W-1 and never wrap.

Decomposition:
- Shared package holds:
  - CRC_INIT and CRC_RESIDUE constants.
  - State encoding (IDLE/ACCUM/DONE).
  - eof_bytes encoding, where 0 means 8 bytes.
- One natural sub-module: crc_bytes (existing), instantiated once to supply the seven partial-word taps.
- The 8-byte full-word update is a CRC32_D64 instance.
- The controller itself contains only the FSM, crc_reg, tap mux, compare and counters.

Test Plan:
- Good frame: 64-byte frame with correct FCS, 8 words, eof_bytes=0 -> crc_done and crc_ok 1 cycle after eof; good_cnt=1.
- Corrupted frame: same frame with bit 0 of byte 20 flipped -> crc_bad pulse; bad_cnt=1, good_cnt unchanged.
- Partial last word: 67-byte frame (eof_bytes=3) with correct FCS -> crc_ok. Repeat with eof_bytes=4 and the same data -> crc_bad.
- Mid-frame events:
  - abort in word 4 -> frame_dropped pulse, no crc_done, counters unchanged.
  - Separately, sof in word 4 followed by a valid 64-byte frame -> one frame_dropped then crc_ok.
- Back-to-back and gaps: two good frames with sof in the DONE cycle, plus data_valid gaps of 3 idle cycles inside frame 2 -> two crc_ok pulses; good_cnt=2.
- Reset and saturation:
  - reset asserted mid-frame -> all outputs 0 next cycle, no pulses.
  - With CNT_W=2, send 5 good frames -> good_cnt stays at 3.
